// File: rtl/fpu_pkg.sv
// Shared FPU constants and record types used by the unpack, divide, multiply and
// post-divide normalize/round blocks.
package fpu_pkg;

  localparam int unsigned MANT_W = 23;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned BIAS   = (32'd1 << (EXP_W - 32'd1)) - 32'd1;

  // Normalized quotient waiting for rounding; exponent is wide enough never to wrap
  typedef struct packed {
    logic                sign;
    logic [EXP_W+1:0]    exp;
    logic [MANT_W-1:0]   frac;
    logic                g;
    logic                s;
    logic                zero;
  } s1_rec_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

endpackage

// File: rtl/fpu_div_normalize_round_if.sv
// Upstream operand offer and downstream result channels of the post-divide stage.
interface fpu_div_normalize_round_if #(
  parameter int unsigned MANT_W = fpu_pkg::MANT_W,
  parameter int unsigned EXP_W  = fpu_pkg::EXP_W
);

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W+1:0]  in_exp;
  logic [MANT_W+2:0] in_quot;
  logic              in_rem_nz;
  logic              in_zero;

  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_frac;
  logic              out_overflow;
  logic              out_underflow;
  logic              out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_quot, in_rem_nz, in_zero, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_frac,
           out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_quot, in_rem_nz, in_zero, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_frac,
           out_overflow, out_underflow, out_inexact
  );

endinterface

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even of a fraction with guard/sticky bits; a carry out of the
// fraction bumps the exponent. Shared by the divide and multiply paths.
module fpu_round_rne #(
  parameter int unsigned MANT_W = 23,
  parameter int unsigned EXP_W  = 8
) (
  input  logic [MANT_W-1:0] frac_i,
  input  logic              g_i,
  input  logic              s_i,
  input  logic [EXP_W+1:0]  exp_i,
  output logic [MANT_W-1:0] frac_o,
  output logic [EXP_W+1:0]  exp_o
);

  logic inc_c;
  logic carry_c;

  // On carry the wrapped fraction is already zero, i.e. 1.000.. at exponent+1
  always_comb begin
    inc_c             = g_i & (s_i | frac_i[0]);
    {carry_c, frac_o} = {1'b0, frac_i} + (MANT_W+1)'(inc_c);
    exp_o             = carry_c ? exp_i + (EXP_W+2)'(1) : exp_i;
  end

endmodule

// File: rtl/fpu_div_normalize_round.sv
// Post-divide stage: normalizes the raw quotient, rounds to nearest-even and
// saturates/flushes out-of-range exponents. Two pipeline stages, one result per cycle.
module fpu_div_normalize_round #(
  parameter int unsigned MANT_W = fpu_pkg::MANT_W,
  parameter int unsigned EXP_W  = fpu_pkg::EXP_W
) (
  input  logic                            clk,
  input  logic                            arst_n,
  fpu_div_normalize_round_if.slave        bus
);

  import fpu_pkg::flags_t;

  localparam int unsigned      QW   = MANT_W + 3;
  localparam int unsigned      EW   = EXP_W + 2;
  localparam logic [EW-1:0]    EMAX = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic              sign;
    logic [EW-1:0]     exp;
    logic [MANT_W-1:0] frac;
    logic              g;
    logic              s;
    logic              zero;
  } s1_t;

  logic              s2_en_c;
  logic [QW-2:0]     norm_c;
  logic [EW-1:0]     e1_c;
  logic [MANT_W-1:0] frac_r_c;
  logic [EW-1:0]     e2_c;

  s1_t               s1_d, s1_q;
  logic              s1_valid_d, s1_valid_q;
  logic              out_valid_d, out_valid_q;
  logic              out_sign_d, out_sign_q;
  logic [EXP_W-1:0]  out_exp_d, out_exp_q;
  logic [MANT_W-1:0] out_frac_d, out_frac_q;
  flags_t            flags_d, flags_q;

  // Output stage can take new data when empty or being drained this cycle
  assign s2_en_c      = !out_valid_q | bus.out_ready;
  assign bus.in_ready = !s1_valid_q | s2_en_c;

  // Quotient in [0.5,1) is shifted up one place; the hidden bit is dropped here
  always_comb begin
    norm_c = bus.in_quot[QW-2:0];
    e1_c   = bus.in_exp;
    if (!bus.in_quot[QW-1]) begin
      norm_c = {bus.in_quot[QW-3:0], 1'b0};
      e1_c   = bus.in_exp - EW'(1);
    end
  end

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (bus.in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d.sign = bus.in_sign;
        s1_d.exp  = e1_c;
        s1_d.frac = norm_c[QW-2:2];
        s1_d.g    = norm_c[1];
        s1_d.s    = norm_c[0] | bus.in_rem_nz;
        s1_d.zero = bus.in_zero;
      end
    end
  end

  fpu_round_rne #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_round (
    .frac_i (s1_q.frac),
    .g_i    (s1_q.g),
    .s_i    (s1_q.s),
    .exp_i  (s1_q.exp),
    .frac_o (frac_r_c),
    .exp_o  (e2_c)
  );

  // Result select: zero, then overflow, then underflow flush, then normal
  always_comb begin
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_frac_d  = out_frac_q;
    flags_d     = flags_q;
    if (s2_en_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d = s1_q.sign;
        flags_d    = '0;
        if (s1_q.zero) begin
          out_exp_d  = '0;
          out_frac_d = '0;
        end else if (!e2_c[EW-1] && (e2_c >= EMAX)) begin
          out_exp_d        = '1;
          out_frac_d       = '0;
          flags_d.overflow = 1'b1;
          flags_d.inexact  = 1'b1;
        end else if (e2_c[EW-1] || (e2_c == '0)) begin
          out_exp_d         = '0;
          out_frac_d        = '0;
          flags_d.underflow = 1'b1;
          flags_d.inexact   = 1'b1;
        end else begin
          out_exp_d       = e2_c[EXP_W-1:0];
          out_frac_d      = frac_r_c;
          flags_d.inexact = s1_q.g | s1_q.s;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_frac_q  <= out_frac_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_sign      = out_sign_q;
  assign bus.out_exp       = out_exp_q;
  assign bus.out_frac      = out_frac_q;
  assign bus.out_overflow  = flags_q.overflow;
  assign bus.out_underflow = flags_q.underflow;
  assign bus.out_inexact   = flags_q.inexact;

endmodule

// File: doc/fpu_div_normalize_round.md
Name: fpu_div_normalize_round

Overview:
- Post-divide stage of the FPU mantissa-division path; consumes the raw quotient, remainder-nonzero flag and pre-biased exponent produced by the mantissa divider.
- Normalizes the quotient, which arrives in the range [0.5, 2), then rounds to nearest-even and adjusts the exponent.
- Detects overflow and underflow, then emits a packed sign/exponent/fraction result.
- Two-stage pipeline with a valid/ready handshake on both sides; throughput is 1 result per cycle.

Parameters:
- MANT_W, 23, stored fraction width, excluding the hidden bit.
- EXP_W, 8, stored exponent width; BIAS = 2^(EXP_W-1)-1 is derived internally.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream offers an operand set.
- in_ready  out  1  block accepts the offer this cycle.
- in_sign  in  1  result sign (sa ^ sb).
- in_exp  in  EXP_W+2  signed two's complement, value ea - eb + BIAS.
- in_quot  in  MANT_W+3  unsigned quotient; value = in_quot / 2^(MANT_W+2).
- in_rem_nz  in  1  divider remainder is nonzero.
- in_zero  in  1  dividend is zero; forces a signed-zero result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  biased exponent.
- out_frac  out  MANT_W  fraction, hidden bit dropped.
- out_overflow  out  1  result saturated to infinity.
- out_underflow  out  1  result flushed to zero.
- out_inexact  out  1  precision was lost.

Behaviour:
- Reset:
  - arst_n low forces s1_valid=0 and s2_valid=0 immediately; all outputs read 0.
  - Reset asserted mid-operation discards all in-flight data with no partial output.
  - in_ready=1 from the first cycle after reset release.
- Handshake:
  - A transfer occurs when valid & ready are both high.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - in_ready = !s1_valid | !s2_valid | out_ready. This allows full throughput and stalls only when both stages are full and downstream is stalled.
- Latency: 2 cycles from input accept to out_valid, when unstalled.
- Stage 1 (normalize):
  - If in_quot[MANT_W+2]=1: N = in_quot and E = in_exp.
  - Otherwise: N = in_quot << 1 and E = in_exp - 1.
  - in_quot[MANT_W+2:MANT_W+1]=00 cannot occur (divisor normalized); it is treated as the shift-by-1 case.
  - Field extraction from N: hidden=N[MANT_W+2], frac=N[MANT_W+1:2], G=N[1], S=N[0] | in_rem_nz.
  - Register sign, E, frac, G, S and zero.
- Stage 2 (round and check):
  - inc = G & (S | frac[0]).
  - {carry, frac_r} = frac + inc. If carry=1: frac_r = 0 and E = E + 1.
  - inexact = G | S.
- Priority, highest first:
  1. zero: exp=0, frac=0, all flags 0, sign kept.
  2. E >= 2^EXP_W-1: overflow=1, exp all ones, frac=0, inexact=1.
  3. E <= 0: underflow=1, exp=0, frac=0, inexact=1. There is no denormal support; the result is flushed.
  4. Otherwise: exp=E[EXP_W-1:0], frac=frac_r.
- Width rule: E is carried in EXP_W+2 bits through both stages, so the exponent never wraps.
- Simultaneous accept and emit in the same cycle is legal and moves both stages.

Decomposition:
- fpu_pkg holds the following items, shared with the unpack and divider blocks:
  - MANT_W, EXP_W, BIAS constants.
  - Typedef for a stage-1 record {sign, exp, frac, g, s, zero}.
  - Typedef for a flags struct {overflow, underflow, inexact}.
- One sub-module: fpu_round_rne, combinational. Inputs are frac, G, S and E; outputs are frac_r and the adjusted E. It is instantiated in stage 2 and reused by the multiply path.

Test Plan:
All scenarios use MANT_W=4, EXP_W=4, BIAS=7.
1. Exact result: quot=7'b1100000, exp=7, rem_nz=0 -> exp=7, frac=1000, flags=000, after 2 cycles.
2. Normalize shift with sticky: quot=7'b0101010, exp=7, rem_nz=1 -> exp=6, frac=0101, inexact=1.
3. Round carry-out:
   - quot=7'b1111111, exp=7 -> exp=8, frac=0000, inexact=1.
   - Tie-even case: quot=7'b1000110 -> frac=0010.
   - Tie-even case: quot=7'b1000010 -> frac=0000, inexact=1.
4. Exponent limits:
   - exp=15, quot=7'b1000000 -> overflow=1, exp=1111, frac=0000.
   - exp=1, quot=7'b0100000 -> underflow=1, result zero.
   - in_zero=1, sign=1 -> sign=1, exp=0, frac=0, flags=0.
5. Backpressure: stream 4 back-to-back inputs with out_ready=0 for 3 cycles.
   - in_ready drops once 2 results are held.
   - Held out_* stay stable.
   - All 4 results emerge in order; none are lost or duplicated.
6. Reset: assert arst_n low while both stages are valid -> out_valid=0 asynchronously; after release, the first new input produces its result after exactly 2 cycles.
